clk_div_ctrl: RTL and testbench
===============================

// Module: clk_div_ctrl
// PURPOSE
//   Runtime-programmable divide-by-2^N clock generator with a glitch-free ratio-change controller.
//   Sequences ratio updates so that a new N takes effect only at a full output-period boundary.
//   clk_out never shows a runt pulse.
//   Sits between config/control logic (valid/ready request) and downstream slow-clock consumers.
// PARAMETERS
//   MAX_N      8   largest legal divide exponent; counter width = MAX_N bits
//   DEFAULT_N  5   exponent loaded at reset (1..MAX_N); /32 on a 50 MHz clk_in
//   NW         $clog2(MAX_N+1)  width of exponent fields (derived, do not override)
// PORTS
//   clk_in     in   1      single clock; all logic on posedge
//   rst        in   1      asynchronous, active-high reset
//   enable     in   1      1 = counter runs; 0 = counter and clk_out frozen
//   cfg_valid  in   1      new exponent request
//   cfg_n      in   NW     requested exponent
//   cfg_ready  out  1      controller can accept a request
//   cfg_done   out  1      1-cycle pulse: requested exponent now active
//   cfg_err    out  1      1-cycle pulse: request rejected (illegal cfg_n)
//   cur_n      out  NW     exponent currently in force
//   clk_out    out  1      divided clock, registered
//   tick       out  1      high during last clk_in cycle of each clk_out period
// BEHAVIOUR
//   - Reset (async, any time): cnt=0, cur_n=DEFAULT_N, clk_out=0, cfg_done=0, cfg_err=0, FSM=IDLE.
//     Any pending request is discarded; no cfg_done for it.
//   - Period P = 2^cur_n. While enable=1, cnt counts 0..P-1 and wraps to 0; enable=0 holds cnt.
//   - clk_out is a flop, 0 while cnt in [0,P/2) and 1 while cnt in [P/2,P).
//     clk_out always equals bit cur_n-1 of cnt; no combinational path from any input to clk_out.
//   - tick = enable & (cnt == P-1). Reset value 0.
//   - FSM states: IDLE, PEND.
//   - IDLE: cfg_ready=1. Handshake is cfg_valid & cfg_ready in the same cycle.
//     - Legal cfg_n (1..MAX_N): latch pend_n, go to PEND.
//     - Illegal cfg_n (0 or >MAX_N): cfg_err=1 next cycle, stay in IDLE; cur_n and cnt unchanged.
//   - PEND: cfg_ready=0; cfg_valid ignored.
//     - Commit on the first PEND cycle with enable=1 and cnt==P-1 (old P).
//     - A request accepted in a cycle with cnt==P-1 commits at the following period end, not the current one.
//     - Commit edge: cur_n<=pend_n, cnt<=0, clk_out<=0, cfg_done=1 for one cycle, FSM->IDLE.
//     - cfg_ready=1 again in the cycle cfg_done is high.
//   - Request for cur_n itself is legal: it goes through PEND and commits normally; the waveform is unchanged.
//   - enable=0 in PEND: wait indefinitely with no timeout. The commit happens after enable returns and the period completes.
//   - Ratio change is glitch-free: every clk_out high and low phase is exactly P/2 cycles of the P in force when that phase began.
//   - cnt is compared only on its low cur_n bits; upper bits are held 0.
// TESTING
//   1 Reset release, enable=1, DEFAULT_N=5 -> clk_out low cycles 0-15, high 16-31, repeating.
//     tick at cnt=31 only; cur_n=5; cfg_ready=1.
//   2 cfg_n=2 accepted at cnt=10 -> cfg_ready low until commit.
//     Commit after the cnt=31 cycle with cfg_done pulse; then period 4 (2 low/2 high), cur_n=2.
//   3 cfg_n=0, then cfg_n=9 -> cfg_err pulse each time; cfg_ready stays 1; cur_n=5; clk_out undisturbed.
//   4 Accept cfg_n=3 at cnt=31 -> no commit at this wrap; commit at next cnt=31. Then period 8.
//   5 enable=0 at cnt=20 while in PEND -> cnt and clk_out(=1) frozen, no cfg_done.
//     enable=1 after 50 cycles -> commit when cnt reaches 31.
//   6 Assert rst in PEND at cnt=12 -> all outputs at reset values; cfg_done never pulses; cur_n=5.
//     Also cfg_n=MAX_N=8 -> period 256, high phase 128.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// Divide-by-2^N clock generator whose exponent can be changed at runtime;
// a new exponent only takes effect at the end of a complete output period.
module clk_div_ctrl #(
  parameter int MAX_N     = 8,
  parameter int DEFAULT_N = 5,
  parameter int NW        = $clog2(MAX_N + 1)
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          enable,
  input  logic          cfg_valid,
  input  logic [NW-1:0] cfg_n,
  output logic          cfg_ready,
  output logic          cfg_done,
  output logic          cfg_err,
  output logic [NW-1:0] cur_n,
  output logic          clk_out,
  output logic          tick
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [NW-1:0] DEF_N   = NW'(DEFAULT_N);
  localparam logic [NW-1:0] MAX_NV  = NW'(MAX_N);
  localparam logic [NW-1:0] ONE_N   = NW'(1);

  // All-ones mask over the low n bits of the counter (n = MAX_N gives all ones).
  function automatic logic [MAX_N-1:0] period_mask(input logic [NW-1:0] n);
    logic [MAX_N:0] full;
    full = ({{MAX_N{1'b0}}, 1'b1} << n) - {{MAX_N{1'b0}}, 1'b1};
    return full[MAX_N-1:0];
  endfunction

  function automatic logic [MAX_N-1:0] half_bit(input logic [NW-1:0] n);
    return {{(MAX_N-1){1'b0}}, 1'b1} << (n - ONE_N);
  endfunction

  state_t           state_q, state_d;
  logic [MAX_N-1:0] cnt_q, cnt_d;
  logic [NW-1:0]    cur_n_q, cur_n_d;
  logic [NW-1:0]    pend_n_q, pend_n_d;
  logic             clk_out_q, clk_out_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [MAX_N-1:0] mask_s;
  logic             at_end_s;
  logic             legal_s;
  logic             commit_s;

  // Period-end detection on the low cur_n bits, plus request legality.
  always_comb begin
    mask_s   = period_mask(cur_n_q);
    at_end_s = ((cnt_q & mask_s) == mask_s);
    legal_s  = (cfg_n >= ONE_N) && (cfg_n <= MAX_NV);
    commit_s = (state_q == PEND) && enable && at_end_s;
  end

  // Next-state logic: handshake, commit sequencing and the period counter.
  always_comb begin
    state_d  = state_q;
    pend_n_d = pend_n_q;
    cur_n_d  = cur_n_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (legal_s) begin
            pend_n_d = cfg_n;
            state_d  = PEND;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      PEND: begin
        if (commit_s) begin
          cur_n_d = pend_n_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = PEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Commit restarts the counter so the new period begins with a full low phase.
    if (commit_s) begin
      cnt_d = {MAX_N{1'b0}};
    end else if (enable) begin
      if (at_end_s) begin
        cnt_d = {MAX_N{1'b0}};
      end else begin
        cnt_d = (cnt_q + {{(MAX_N-1){1'b0}}, 1'b1}) & mask_s;
      end
    end else begin
      cnt_d = cnt_q & mask_s;
    end

    clk_out_d = |(cnt_d & half_bit(cur_n_d));
    ready_d   = (state_d == IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= {MAX_N{1'b0}};
      cur_n_q   <= DEF_N;
      pend_n_q  <= DEF_N;
      clk_out_q <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_n_q   <= cur_n_d;
      pend_n_q  <= pend_n_d;
      clk_out_q <= clk_out_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign cfg_ready = ready_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign cur_n     = cur_n_q;
  assign clk_out   = clk_out_q;
  assign tick      = enable & at_end_s;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: period shape, ratio changes, rejects,
// enable freeze, reset during a pending change and the largest exponent.
module tb_clk_div_ctrl;

  localparam int MAX_N = 8;
  localparam int NW    = 4;

  logic          clk_in;
  logic          rst;
  logic          enable;
  logic          cfg_valid;
  logic [NW-1:0] cfg_n;
  logic          cfg_ready;
  logic          cfg_done;
  logic          cfg_err;
  logic [NW-1:0] cur_n;
  logic          clk_out;
  logic          tick;

  int vectors;
  int miscompares;

  clk_div_ctrl #(.MAX_N(8), .DEFAULT_N(5)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_n     (cfg_n),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .cur_n     (cur_n),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    enable    = 1'b1;
    cfg_valid = 1'b0;
    cfg_n     = 4'd0;
    cyc(3);
    rst = 1'b0;

    // 1: reset values, then two /32 periods
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_cur_n", 32'(cur_n), 32'd5);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_done", 32'(cfg_done), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    for (int i = 1; i <= 64; i++) begin
      cyc(1);
      chk("p32_clk_out", 32'(clk_out), 32'((i % 32) >= 16));
      chk("p32_tick", 32'(tick), 32'((i % 32) == 31));
    end

    // 2: cfg_n=2 accepted at cnt=10, commits after cnt=31
    cyc(10);
    cfg_valid = 1'b1;
    cfg_n     = 4'd2;
    cyc(1);
    cfg_valid = 1'b0;
    chk("t2_ready_low", 32'(cfg_ready), 32'd0);
    for (int i = 12; i <= 31; i++) begin
      cyc(1);
      chk("t2_wait_done", 32'(cfg_done), 32'd0);
      chk("t2_wait_ready", 32'(cfg_ready), 32'd0);
      chk("t2_wait_cur_n", 32'(cur_n), 32'd5);
    end
    chk("t2_tick_end", 32'(tick), 32'd1);
    chk("t2_clk_hi_end", 32'(clk_out), 32'd1);
    cyc(1);
    chk("t2_done", 32'(cfg_done), 32'd1);
    chk("t2_cur_n", 32'(cur_n), 32'd2);
    chk("t2_clk_out0", 32'(clk_out), 32'd0);
    chk("t2_ready_back", 32'(cfg_ready), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      chk("p4_clk_out", 32'(clk_out), 32'((i % 4) >= 2));
      chk("p4_tick", 32'(tick), 32'((i % 4) == 3));
      chk("p4_done", 32'(cfg_done), 32'd0);
    end

    // back to /32: accept at cnt=0, commit after cnt=3
    cfg_valid = 1'b1;
    cfg_n     = 4'd5;
    cyc(1);
    cfg_valid = 1'b0;
    cyc(2);
    chk("r5a_done_early", 32'(cfg_done), 32'd0);
    cyc(1);
    chk("r5a_done", 32'(cfg_done), 32'd1);
    chk("r5a_cur_n", 32'(cur_n), 32'd5);

    // 3: illegal exponents 0 and 9
    cfg_valid = 1'b1;
    cfg_n     = 4'd0;
    cyc(1);
    chk("t3_err0", 32'(cfg_err), 32'd1);
    chk("t3_ready0", 32'(cfg_ready), 32'd1);
    chk("t3_cur_n0", 32'(cur_n), 32'd5);
    cfg_n = 4'd9;
    cyc(1);
    chk("t3_err9", 32'(cfg_err), 32'd1);
    chk("t3_ready9", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b0;
    cyc(1);
    chk("t3_err_clear", 32'(cfg_err), 32'd0);
    chk("t3_cur_n", 32'(cur_n), 32'd5);
    for (int i = 4; i <= 31; i++) begin
      cyc(1);
      chk("t3_clk_out", 32'(clk_out), 32'(i >= 16));
    end
    chk("t3_tick31", 32'(tick), 32'd1);

    // 4: cfg_n=3 accepted at cnt=31 commits one full period later
    cfg_valid = 1'b1;
    cfg_n     = 4'd3;
    cyc(1);
    cfg_valid = 1'b0;
    chk("t4_no_commit", 32'(cfg_done), 32'd0);
    chk("t4_cur_n_old", 32'(cur_n), 32'd5);
    chk("t4_ready_low", 32'(cfg_ready), 32'd0);
    for (int i = 1; i <= 31; i++) begin
      cyc(1);
      chk("t4_wait_done", 32'(cfg_done), 32'd0);
      chk("t4_wait_clk", 32'(clk_out), 32'(i >= 16));
    end
    cyc(1);
    chk("t4_done", 32'(cfg_done), 32'd1);
    chk("t4_cur_n", 32'(cur_n), 32'd3);
    chk("t4_clk_out0", 32'(clk_out), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      cyc(1);
      chk("p8_clk_out", 32'(clk_out), 32'((i % 8) >= 4));
      chk("p8_tick", 32'(tick), 32'((i % 8) == 7));
    end

    // back to /32: accept at cnt=0, commit after cnt=7
    cfg_valid = 1'b1;
    cfg_n     = 4'd5;
    cyc(1);
    cfg_valid = 1'b0;
    cyc(6);
    chk("r5b_done_early", 32'(cfg_done), 32'd0);
    cyc(1);
    chk("r5b_done", 32'(cfg_done), 32'd1);
    chk("r5b_cur_n", 32'(cur_n), 32'd5);

    // 5: enable low at cnt=20 while pending
    cyc(5);
    cfg_valid = 1'b1;
    cfg_n     = 4'd4;
    cyc(1);
    cfg_valid = 1'b0;
    cyc(14);
    chk("t5_clk_hi20", 32'(clk_out), 32'd1);
    enable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      chk("t5_frz_clk", 32'(clk_out), 32'd1);
      chk("t5_frz_tick", 32'(tick), 32'd0);
      chk("t5_frz_done", 32'(cfg_done), 32'd0);
      chk("t5_frz_ready", 32'(cfg_ready), 32'd0);
    end
    enable = 1'b1;
    cyc(11);
    chk("t5_tick31", 32'(tick), 32'd1);
    chk("t5_done_pre", 32'(cfg_done), 32'd0);
    chk("t5_cur_n_pre", 32'(cur_n), 32'd5);
    cyc(1);
    chk("t5_done", 32'(cfg_done), 32'd1);
    chk("t5_cur_n", 32'(cur_n), 32'd4);
    chk("t5_clk_out0", 32'(clk_out), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      cyc(1);
      chk("p16_clk_out", 32'(clk_out), 32'((i % 16) >= 8));
      chk("p16_tick", 32'(tick), 32'((i % 16) == 15));
    end

    // 6: reset while pending at cnt=12
    cfg_valid = 1'b1;
    cfg_n     = 4'd2;
    cyc(1);
    cfg_valid = 1'b0;
    cyc(11);
    chk("t6_clk_hi12", 32'(clk_out), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_clk", 32'(clk_out), 32'd0);
    chk("t6_rst_cur_n", 32'(cur_n), 32'd5);
    chk("t6_rst_ready", 32'(cfg_ready), 32'd1);
    chk("t6_rst_done", 32'(cfg_done), 32'd0);
    chk("t6_rst_err", 32'(cfg_err), 32'd0);
    chk("t6_rst_tick", 32'(tick), 32'd0);
    cyc(1);
    rst = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      chk("t6_no_done", 32'(cfg_done), 32'd0);
      chk("t6_clk_out", 32'(clk_out), 32'((i % 32) >= 16));
      chk("t6_cur_n", 32'(cur_n), 32'd5);
    end

    // largest exponent: /256
    cfg_valid = 1'b1;
    cfg_n     = 4'd8;
    cyc(1);
    cfg_valid = 1'b0;
    cyc(22);
    chk("t6_tick31", 32'(tick), 32'd1);
    cyc(1);
    chk("t6_done8", 32'(cfg_done), 32'd1);
    chk("t6_cur_n8", 32'(cur_n), 32'd8);
    for (int i = 1; i <= 256; i++) begin
      cyc(1);
      chk("p256_clk_out", 32'(clk_out), 32'((i % 256) >= 128));
      chk("p256_tick", 32'(tick), 32'((i % 256) == 255));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
